// File: rtl/constants_pkg.sv
// Shared pd4 constants plus the fetch-stage state type.
// Also used by fetch_stage, whose optional perf counters are enabled by FETCH_PERF_CNT_EN.
package constants_pkg;

    localparam int          ADDR_WIDTH    = 32;
    localparam int          DATA_WIDTH    = 32;
    localparam logic [31:0] MEM_BASE_ADDR = 32'h0100_0000;
    localparam logic [31:0] WORD_STRIDE   = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding {pc, insn} pairs between instruction memory and decode.
// Clear empties the queue in one cycle; a push on the same cycle as clear is dropped.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    import constants_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_C);
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset; the count masks stale entries.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/fetch_stage.sv
// pd4 instruction fetch: PC ownership, credit-limited imem requests, response queue to decode.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_bubbles counters.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = constants_pkg::ADDR_WIDTH,
    parameter int                    DATA_WIDTH = constants_pkg::DATA_WIDTH,
    parameter int                    QDEPTH     = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(constants_pkg::MEM_BASE_ADDR)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    output logic [DATA_WIDTH-1:0] dec_insn
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_bubbles
`endif
);
    import constants_pkg::*;

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CW:0]           CREDITS = (CW+1)'(QDEPTH);
    localparam logic [ADDR_WIDTH-1:0] STRIDE  = ADDR_WIDTH'(WORD_STRIDE);
    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_FETCH = 2'(FETCH);
    localparam logic [1:0] S_FLUSH = 2'(FLUSH);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]         inflight_q, inflight_d, drop_q, drop_d;
    logic [CW-1:0]         q_count;
    logic                  q_empty, q_full;
    logic [EW-1:0]         q_rdata;
    logic                  accept, rsp_fire, push, pop;
    logic [ADDR_WIDTH-1:0] redir_pc_aligned;
    logic [CW:0]           credit_used;

    assign redir_pc_aligned = redirect_pc & ~ADDR_WIDTH'(3);
    assign credit_used      = {1'b0, inflight_q} + {1'b0, q_count};

    // Credits cover both in-flight and queued entries, so every response finds a slot.
    assign imem_req_valid = (state_q == S_FETCH) && !redirect_valid && (credit_used < CREDITS);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && (inflight_q != '0);
    assign push           = rsp_fire && !redirect_valid && (drop_q == '0);

    assign dec_valid = !q_empty && !redirect_valid;
    assign pop       = dec_valid && dec_ready;
    assign dec_pc    = q_empty ? '0 : q_rdata[EW-1:DATA_WIDTH];
    assign dec_insn  = q_empty ? '0 : q_rdata[DATA_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + CW'(accept) - CW'(rsp_fire);
        if (accept)                    pc_d     = pc_q + STRIDE;
        if (push)                      rsp_pc_d = rsp_pc_q + STRIDE;
        if (rsp_fire && drop_q != '0)  drop_d   = drop_q - 1'b1;
        // Redirect wins: everything still outstanding after this cycle becomes a drop.
        if (redirect_valid) begin
            pc_d     = redir_pc_aligned;
            rsp_pc_d = redir_pc_aligned;
            drop_d   = inflight_d;
        end
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (redirect_valid && inflight_d != '0) state_d = S_FLUSH;
            S_FLUSH: if (drop_d == '0) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (redirect_valid),
        .wdata ({rsp_pc_q, imem_rsp_data}),
        .rdata (q_rdata),
        .empty (q_empty),
        .full  (q_full),
        .count (q_count)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, bubbles_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            if (push) fetched_q <= fetched_q + 32'd1;
            if (dec_ready && !dec_valid && state_q == S_FETCH) bubbles_q <= bubbles_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`endif

    // A response with nothing outstanding is a memory protocol violation.
    rsp_without_request: assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && inflight_q == '0));

    push_into_full_queue: assert property (@(posedge clk) disable iff (reset)
        !(push && q_full && !pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order latency-randomised memory model plus a PC-sequence reference.
module tb_fetch_stage;

    localparam int          QD   = 2;
    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_pc, dec_insn;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.QDEPTH(QD)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_insn       (dec_insn)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Stimulus knobs for the next cycle
    logic        s_ready, s_dec_ready, s_redir;
    logic [31:0] s_redir_pc;
    int          lat_min = 1, lat_max = 1;

    // Memory model: in-order outstanding requests with their due cycle
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    // Reference model: next expected request address and next expected decoded PC
    logic [31:0] m_req_addr, m_dec_pc;

    // Per-cycle observations
    logic        o_req_valid, o_dec_valid, o_acc, o_pop, o_rsp;
    logic [31:0] o_acc_addr, o_exp_acc_addr, o_pc, o_insn, o_exp_pc, o_exp_insn;
    int          o_mq_pre, o_mq;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        s_ready = 1'b0; s_dec_ready = 1'b0; s_redir = 1'b0; s_redir_pc = '0;
        repeat (2) @(negedge clk);
        mq_addr.delete(); mq_due.delete();
        m_req_addr = BASE; m_dec_pc = BASE;
        reset = 1'b0;
    endtask

    task automatic drive_cycle();
        @(negedge clk);
        imem_req_ready = s_ready;
        dec_ready      = s_dec_ready;
        redirect_valid = s_redir;
        redirect_pc    = s_redir_pc;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = insn_of(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        o_rsp          = imem_rsp_valid;
        o_req_valid    = imem_req_valid;
        o_dec_valid    = dec_valid;
        o_mq_pre       = mq_addr.size();
        o_acc          = imem_req_valid && imem_req_ready;
        o_acc_addr     = imem_req_addr;
        o_exp_acc_addr = m_req_addr;
        if (o_acc) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            m_req_addr = m_req_addr + 32'd4;
        end
        o_pop      = dec_valid && dec_ready;
        o_pc       = dec_pc;
        o_insn     = dec_insn;
        o_exp_pc   = m_dec_pc;
        o_exp_insn = insn_of(m_dec_pc);
        if (o_pop) m_dec_pc = m_dec_pc + 32'd4;
        if (s_redir) begin
            m_req_addr = s_redir_pc & ~32'd3;
            m_dec_pc   = s_redir_pc & ~32'd3;
        end
        o_mq = mq_addr.size();
        cyc++;
    endtask

    task automatic test_reset();
        do_reset();
        s_ready = 1'b1; s_dec_ready = 1'b0; lat_min = 1; lat_max = 2;
        repeat (6) drive_cycle();
        // Reset coincident with a redirect and live traffic
        @(negedge clk);
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0200_0000;
        imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
        checks++;
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid got %b want 0", dec_valid); end
        checks++;
        if (dec_pc !== 32'h0 || dec_insn !== 32'h0) begin errors++; $display("FAIL reset_dec_data got %h/%h want 0/0", dec_pc, dec_insn); end
        mq_addr.delete(); mq_due.delete();
        m_req_addr = BASE; m_dec_pc = BASE;
        s_redir = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_req_valid got %b want 0", imem_req_valid); end
        drive_cycle();
        checks++;
        if (o_acc !== 1'b1 || o_acc_addr !== BASE) begin errors++; $display("FAIL reset_first_req got %b/%h want 1/%h", o_acc, o_acc_addr, BASE); end
    endtask

    task automatic test_sequential();
        int first_acc = -1, first_pop = -1, n_acc = 0, n_pop = 0;
        do_reset();
        s_ready = 1'b1; s_dec_ready = 1'b1; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 40; i++) begin
            drive_cycle();
            if (o_acc) begin
                if (first_acc < 0) first_acc = cyc;
                n_acc++;
                checks++;
                if (o_acc_addr !== o_exp_acc_addr) begin errors++; $display("FAIL seq_req_addr got %h want %h", o_acc_addr, o_exp_acc_addr); end
            end
            if (o_pop) begin
                if (first_pop < 0) first_pop = cyc;
                n_pop++;
                checks++;
                if (o_pc !== o_exp_pc || o_insn !== o_exp_insn) begin errors++; $display("FAIL seq_dec got %h/%h want %h/%h", o_pc, o_insn, o_exp_pc, o_exp_insn); end
            end
        end
        checks++;
        if (first_pop - first_acc != 2) begin errors++; $display("FAIL seq_latency got %0d want 2", first_pop - first_acc); end
        checks++;
        if (n_acc < 20 || n_pop < 20) begin errors++; $display("FAIL seq_throughput got %0d/%0d want >=20/>=20", n_acc, n_pop); end
    endtask

    task automatic test_backpressure();
        int n_acc = 0, n_pop = 0;
        do_reset();
        s_ready = 1'b1; s_dec_ready = 1'b0; lat_min = 1; lat_max = 2;
        for (int i = 0; i < 20; i++) begin
            drive_cycle();
            if (o_acc) n_acc++;
        end
        checks++;
        if (n_acc != QD) begin errors++; $display("FAIL bp_accepts got %0d want %0d", n_acc, QD); end
        checks++;
        if (o_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stalled got %b want 0", o_req_valid); end
        s_dec_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            drive_cycle();
            if (o_pop) begin
                n_pop++;
                checks++;
                if (o_pc !== o_exp_pc || o_insn !== o_exp_insn) begin errors++; $display("FAIL bp_drain got %h/%h want %h/%h", o_pc, o_insn, o_exp_pc, o_exp_insn); end
            end
        end
        checks++;
        if (n_pop < QD + 5) begin errors++; $display("FAIL bp_resume got %0d pops want >=%0d", n_pop, QD + 5); end
    endtask

    task automatic test_redirect_inflight();
        logic [31:0] first_pc = '1;
        bit          seen = 0;
        int          guard = 0;
        do_reset();
        s_ready = 1'b1; s_dec_ready = 1'b1; lat_min = 4; lat_max = 4;
        do begin drive_cycle(); guard++; end while (o_mq < 2 && guard < 20);
        checks++;
        if (o_mq < 2) begin errors++; $display("FAIL redir_setup_timeout got %0d inflight want 2", o_mq); end
        s_redir = 1'b1; s_redir_pc = 32'h0100_0040;
        drive_cycle();
        s_redir = 1'b0;
        checks++;
        if (o_req_valid !== 1'b0 || o_dec_valid !== 1'b0) begin errors++; $display("FAIL redir_masks got %b/%b want 0/0", o_req_valid, o_dec_valid); end
        for (int i = 0; i < 40; i++) begin
            drive_cycle();
            if (o_pop) begin
                if (!seen) first_pc = o_pc;
                seen = 1;
                checks++;
                if (o_pc !== o_exp_pc || o_insn !== o_exp_insn) begin errors++; $display("FAIL redir_dec got %h/%h want %h/%h", o_pc, o_insn, o_exp_pc, o_exp_insn); end
            end
        end
        checks++;
        if (first_pc !== 32'h0100_0040) begin errors++; $display("FAIL redir_first_pc got %h want 01000040", first_pc); end
    endtask

    task automatic test_redirect_coincident();
        int  guard = 0;
        bit  resumed = 0;
        do_reset();
        s_ready = 1'b1; s_dec_ready = 1'b1; lat_min = 2; lat_max = 3;
        // Wait until a response will arrive and another request is still outstanding
        while (!(mq_addr.size() >= 2 && mq_due[0] <= cyc) && guard < 30) begin drive_cycle(); guard++; end
        checks++;
        if (guard >= 30) begin errors++; $display("FAIL coinc_setup_timeout got %0d cycles want <30", guard); end
        s_redir = 1'b1; s_redir_pc = 32'h0100_0080;
        drive_cycle();
        s_redir = 1'b0;
        checks++;
        if (o_rsp !== 1'b1 || o_acc !== 1'b0) begin errors++; $display("FAIL coinc_events got rsp %b acc %b want 1/0", o_rsp, o_acc); end
        for (int i = 0; i < 30; i++) begin
            drive_cycle();
            if (o_req_valid && !resumed) begin
                resumed = 1;
                checks++;
                if (o_mq_pre != 0) begin errors++; $display("FAIL coinc_flush_wait got %0d outstanding want 0", o_mq_pre); end
            end
            if (o_acc) begin
                checks++;
                if (o_acc_addr !== o_exp_acc_addr) begin errors++; $display("FAIL coinc_req_addr got %h want %h", o_acc_addr, o_exp_acc_addr); end
            end
            if (o_pop) begin
                checks++;
                if (o_pc !== o_exp_pc || o_insn !== o_exp_insn) begin errors++; $display("FAIL coinc_dec got %h/%h want %h/%h", o_pc, o_insn, o_exp_pc, o_exp_insn); end
            end
        end
        checks++;
        if (!resumed) begin errors++; $display("FAIL coinc_resume got 0 want 1"); end
    endtask

    task automatic test_redirect_unaligned();
        logic [31:0] a = '1, p = '1;
        bit          got_a = 0, got_p = 0;
        do_reset();
        s_ready = 1'b1; s_dec_ready = 1'b1; lat_min = 1; lat_max = 3;
        repeat (3) drive_cycle();
        s_redir = 1'b1; s_redir_pc = 32'h0100_0013;
        drive_cycle();
        s_redir = 1'b0;
        for (int i = 0; i < 30; i++) begin
            drive_cycle();
            if (o_acc && !got_a) begin a = o_acc_addr; got_a = 1; end
            if (o_pop && !got_p) begin p = o_pc; got_p = 1; end
        end
        checks++;
        if (a !== 32'h0100_0010) begin errors++; $display("FAIL unaligned_req got %h want 01000010", a); end
        checks++;
        if (p !== 32'h0100_0010) begin errors++; $display("FAIL unaligned_dec got %h want 01000010", p); end
    endtask

    task automatic test_wrap();
        logic [31:0] prev = '0;
        bit          wrapped = 0, popped_zero = 0;
        do_reset();
        s_ready = 1'b1; s_dec_ready = 1'b1; lat_min = 1; lat_max = 1;
        s_redir = 1'b1; s_redir_pc = 32'hFFFF_FFF8;
        drive_cycle();
        s_redir = 1'b0;
        for (int i = 0; i < 30; i++) begin
            drive_cycle();
            if (o_acc) begin
                if (prev == 32'hFFFF_FFFC && o_acc_addr == 32'h0) wrapped = 1;
                prev = o_acc_addr;
            end
            if (o_pop) begin
                if (o_pc == 32'h0 && o_insn == insn_of(32'h0)) popped_zero = 1;
                checks++;
                if (o_pc !== o_exp_pc || o_insn !== o_exp_insn) begin errors++; $display("FAIL wrap_dec got %h/%h want %h/%h", o_pc, o_insn, o_exp_pc, o_exp_insn); end
            end
        end
        checks++;
        if (!wrapped) begin errors++; $display("FAIL wrap_req got last %h want FFFFFFFC then 00000000", prev); end
        checks++;
        if (!popped_zero) begin errors++; $display("FAIL wrap_dec_zero got 0 want 1"); end
    endtask

    task automatic test_random();
        int n_pop = 0;
        do_reset();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            s_ready     = ($urandom_range(3, 0) != 0);
            s_dec_ready = ($urandom_range(3, 0) != 0);
            s_redir     = ($urandom_range(39, 0) == 0);
            s_redir_pc  = BASE + 32'($urandom_range(255, 0));
            drive_cycle();
            if (o_acc) begin
                checks++;
                if (o_acc_addr !== o_exp_acc_addr || o_mq > QD) begin errors++; $display("FAIL rand_req got %h/%0d want %h/<=%0d", o_acc_addr, o_mq, o_exp_acc_addr, QD); end
            end
            if (o_pop) begin
                n_pop++;
                checks++;
                if (o_pc !== o_exp_pc || o_insn !== o_exp_insn) begin errors++; $display("FAIL rand_dec got %h/%h want %h/%h", o_pc, o_insn, o_exp_pc, o_exp_insn); end
            end
        end
        s_redir = 1'b0;
        checks++;
        if (n_pop < 100) begin errors++; $display("FAIL rand_progress got %0d pops want >=100", n_pop); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        int n_pop = 0, n_bub = 0;
        do_reset();
        s_ready = 1'b1; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 200; i++) begin
            s_dec_ready = ($urandom_range(1, 0) != 0);
            drive_cycle();
            if (o_pop) n_pop++;
            if (s_dec_ready && !o_dec_valid) n_bub++;
        end
        s_ready = 1'b0; s_dec_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive_cycle();
            if (o_pop) n_pop++;
            if (s_dec_ready && !o_dec_valid) n_bub++;
        end
        @(posedge clk); #1;
        checks++;
        if (perf_fetched !== 32'(n_pop)) begin errors++; $display("FAIL perf_fetched got %0d want %0d", perf_fetched, n_pop); end
        checks++;
        if (perf_bubbles !== 32'(n_bub)) begin errors++; $display("FAIL perf_bubbles got %0d want %0d", perf_bubbles, n_bub); end
    endtask
`endif

    initial begin
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincident();
        test_redirect_unaligned();
        test_wrap();
        test_random();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
